jtag_tap_param: RTL and testbench
=================================

JTAG_TAP_PARAM -- requirements
Module: jtag_tap_param

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 4; instruction register length, minimum 4.
REQ-002 SHALL have parameter BSR_LEN, default 10; boundary-scan register length, minimum 1.
REQ-003 SHALL have parameter IDCODE_VAL, default 32'h1000_0001; 32-bit device ID, bit 0 = 1.
REQ-004 SHALL have parameter USERCODE_VAL, default 32'h0000_0000; 32-bit user code.
REQ-005 TCK  input  1  sole clock; all flops on TCK rising edge, except TDO on the falling edge.
REQ-006 TRST  input  1  asynchronous, active-high reset.
REQ-007 TMS  input  1  test mode select, sampled on the rising edge.
REQ-008 TDI  input  1  serial data in, sampled on the rising edge.
REQ-009 TDO  output  1  serial data out, changes on the falling edge.
REQ-010 TDO_EN  output  1  high only while in Shift-DR or Shift-IR, falling-edge registered.
REQ-011 state  output  4  current TAP state, encoded per IEEE 1149.1.
REQ-012 LATCH_JTAG_IR  output  IR_WIDTH  active instruction.
REQ-013 BSR_PI  input  BSR_LEN  parallel capture data for the boundary-scan register.
REQ-014 BSR_PO  output  BSR_LEN  boundary-scan update latch.
REQ-015 SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT, IDCODE_SELECT, BYPASS_SELECT, USERCODE_SELECT  output  1 each  one-hot decode of LATCH_JTAG_IR.

Function
REQ-016 The TAP FSM SHALL implement all 16 IEEE 1149.1 states with standard TMS transitions; the state encoding is fixed: TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D.
REQ-017 From any state, five consecutive rising edges with TMS=1 SHALL reach TLR.
REQ-018 In TLR, LATCH_JTAG_IR SHALL load IDCODE on the same rising edge that enters TLR.
REQ-019 Opcodes: SAMPLE=1, EXTEST=2, INTEST=3, IDCODE=7, USERCODE=8, BYPASS=all-ones, each zero-extended to IR_WIDTH; any other opcode SHALL select BYPASS.
REQ-020 Capture-IR SHALL load the IR shift register with {0..., 2'b01}.
REQ-021 Shift-IR SHALL shift LSB-first: TDI enters the MSB, and TDO presents the LSB.
REQ-022 Update-IR SHALL copy the IR shift register to LATCH_JTAG_IR.
REQ-023 Capture-DR SHALL load the selected data register:
- IDCODE: IDCODE_VAL
- USERCODE: USERCODE_VAL
- SAMPLE/EXTEST/INTEST: BSR_PI
- BYPASS: 0
REQ-024 Shift-DR SHALL shift only the selected register, LSB-first; the other data registers SHALL hold.
REQ-025 Update-DR SHALL copy the BSR shift register to BSR_PO only when SAMPLE, EXTEST or INTEST is selected; in all other cases BSR_PO SHALL hold.
REQ-026 Pause, Exit1 and Exit2 states SHALL hold all shift registers unchanged.
REQ-027 TDO SHALL output the LSB of the active shift register on the falling edge while in Shift-IR or Shift-DR; otherwise TDO SHALL hold 0 and TDO_EN SHALL be 0.
REQ-028 Shifting an N-bit register N times SHALL return the captured value unmodified; BYPASS SHALL add exactly one TCK of delay.
REQ-029 LATCH_JTAG_IR and BSR_PO SHALL change only on Update-IR, Update-DR, TLR or reset, never during shifting.

Reset
REQ-030 TRST=1 SHALL asynchronously force:
- state to TLR
- LATCH_JTAG_IR to IDCODE
- BSR_PO, all shift registers, TDO and TDO_EN to 0
REQ-031 A TRST assertion mid-shift SHALL abort the operation without any update to LATCH_JTAG_IR or BSR_PO.
REQ-032 Deassertion of TRST SHALL take effect at the next rising edge; TMS is sampled from that edge.

Structure
REQ-033 Package jtag_pkg SHALL hold the state encoding constants, the opcode constants, and the IR capture pattern.
REQ-034 The TAP FSM SHALL be the sub-module jtag_tap_fsm (inputs TCK, TRST, TMS; outputs state plus capture, shift and update strobes for IR and DR, and TLR); all remaining logic SHALL reside in jtag_tap_param.

Verification
REQ-035 TRST pulse, then 5x TMS=1, then TMS=0 -> state=F then C; LATCH_JTAG_IR=7 (IDCODE).
REQ-036 Default parameters, path to Shift-DR, 32 shifts -> TDO yields 32'h1000_0001, LSB first.
REQ-037 Shift IR with TDI=1111 -> TDO emits 1,0,0,0; after Update-IR, BYPASS_SELECT=1; in DR, TDI pattern 1011 -> TDO 0,1,0,1,1 (one-cycle delay).
REQ-038 IR=EXTEST, BSR_PI=10'h2AA, shift in 10'h155 -> TDO emits 10'h2AA LSB-first; after Update-DR, BSR_PO=10'h155.
REQ-039 IR=EXTEST, shift 5 of 10 bits, assert TRST -> BSR_PO unchanged, state=F, LATCH_JTAG_IR=IDCODE.
REQ-040 Parameter sweep with IR_WIDTH=8 and BSR_LEN=33 -> IR capture reads 8'h01; 33-bit BSR round-trips correctly; opcode 8'h05 decodes as BYPASS.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared TAP definitions: IEEE 1149.1 state encoding, instruction opcodes
// and the fixed pattern loaded into the IR shift register on Capture-IR.
package jtag_pkg;

    typedef enum logic [3:0] {
        ST_EX2_DR   = 4'h0,
        ST_EX1_DR   = 4'h1,
        ST_SH_DR    = 4'h2,
        ST_PAUSE_DR = 4'h3,
        ST_SEL_IR   = 4'h4,
        ST_UPD_DR   = 4'h5,
        ST_CAP_DR   = 4'h6,
        ST_SEL_DR   = 4'h7,
        ST_EX2_IR   = 4'h8,
        ST_EX1_IR   = 4'h9,
        ST_SH_IR    = 4'hA,
        ST_PAUSE_IR = 4'hB,
        ST_RTI      = 4'hC,
        ST_UPD_IR   = 4'hD,
        ST_CAP_IR   = 4'hE,
        ST_TLR      = 4'hF
    } tap_state_t;

    // Opcodes are zero-extended to the IR width; BYPASS is all-ones.
    localparam int unsigned OP_SAMPLE   = 1;
    localparam int unsigned OP_EXTEST   = 2;
    localparam int unsigned OP_INTEST   = 3;
    localparam int unsigned OP_IDCODE   = 7;
    localparam int unsigned OP_USERCODE = 8;

    localparam logic [1:0] IR_CAPTURE = 2'b01;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller; strobes are decoded from the current state except
// tlr, which flags the edge that lands in (or stays in) Test-Logic-Reset.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST,
    input  logic       TMS,
    output logic [3:0] state,
    output logic       capture_ir,
    output logic       shift_ir,
    output logic       update_ir,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr,
    output logic       tlr
);

    tap_state_t state_reg;
    tap_state_t state_next;

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            state_reg <= ST_TLR;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_TLR:      state_next = TMS ? ST_TLR    : ST_RTI;
            ST_RTI:      state_next = TMS ? ST_SEL_DR : ST_RTI;
            ST_SEL_DR:   state_next = TMS ? ST_SEL_IR : ST_CAP_DR;
            ST_CAP_DR:   state_next = TMS ? ST_EX1_DR : ST_SH_DR;
            ST_SH_DR:    state_next = TMS ? ST_EX1_DR : ST_SH_DR;
            ST_EX1_DR:   state_next = TMS ? ST_UPD_DR : ST_PAUSE_DR;
            ST_PAUSE_DR: state_next = TMS ? ST_EX2_DR : ST_PAUSE_DR;
            ST_EX2_DR:   state_next = TMS ? ST_UPD_DR : ST_SH_DR;
            ST_UPD_DR:   state_next = TMS ? ST_SEL_DR : ST_RTI;
            ST_SEL_IR:   state_next = TMS ? ST_TLR    : ST_CAP_IR;
            ST_CAP_IR:   state_next = TMS ? ST_EX1_IR : ST_SH_IR;
            ST_SH_IR:    state_next = TMS ? ST_EX1_IR : ST_SH_IR;
            ST_EX1_IR:   state_next = TMS ? ST_UPD_IR : ST_PAUSE_IR;
            ST_PAUSE_IR: state_next = TMS ? ST_EX2_IR : ST_PAUSE_IR;
            ST_EX2_IR:   state_next = TMS ? ST_UPD_IR : ST_SH_IR;
            ST_UPD_IR:   state_next = TMS ? ST_SEL_DR : ST_RTI;
            default:     state_next = ST_TLR;
        endcase
    end

    assign state      = state_reg;
    assign capture_ir = (state_reg == ST_CAP_IR);
    assign shift_ir   = (state_reg == ST_SH_IR);
    assign update_ir  = (state_reg == ST_UPD_IR);
    assign capture_dr = (state_reg == ST_CAP_DR);
    assign shift_dr   = (state_reg == ST_SH_DR);
    assign update_dr  = (state_reg == ST_UPD_DR);
    assign tlr        = (state_next == ST_TLR);

endmodule

// File: rtl/jtag_tap_param.sv
// Parameterised JTAG TAP: IR, IDCODE, USERCODE, BYPASS and boundary-scan
// registers around jtag_tap_fsm, with TDO launched on the falling edge.
module jtag_tap_param
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH     = 4,
    parameter int          BSR_LEN      = 10,
    parameter logic [31:0] IDCODE_VAL   = 32'h1000_0001,
    parameter logic [31:0] USERCODE_VAL = 32'h0000_0000
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    output logic                TDO_EN,
    output logic [3:0]          state,
    output logic [IR_WIDTH-1:0] LATCH_JTAG_IR,
    input  logic [BSR_LEN-1:0]  BSR_PI,
    output logic [BSR_LEN-1:0]  BSR_PO,
    output logic                SAMPLE_SELECT,
    output logic                EXTEST_SELECT,
    output logic                INTEST_SELECT,
    output logic                IDCODE_SELECT,
    output logic                BYPASS_SELECT,
    output logic                USERCODE_SELECT
);

    localparam logic [IR_WIDTH-1:0] IR_SAMPLE   = IR_WIDTH'(OP_SAMPLE);
    localparam logic [IR_WIDTH-1:0] IR_EXTEST   = IR_WIDTH'(OP_EXTEST);
    localparam logic [IR_WIDTH-1:0] IR_INTEST   = IR_WIDTH'(OP_INTEST);
    localparam logic [IR_WIDTH-1:0] IR_IDCODE   = IR_WIDTH'(OP_IDCODE);
    localparam logic [IR_WIDTH-1:0] IR_USERCODE = IR_WIDTH'(OP_USERCODE);
    localparam logic [IR_WIDTH-1:0] IR_CAP_VAL  = {{(IR_WIDTH-2){1'b0}}, IR_CAPTURE};

    logic capture_ir, shift_ir, update_ir;
    logic capture_dr, shift_dr, update_dr;
    logic tlr;

    logic [IR_WIDTH-1:0] ir_shift_reg;
    logic [31:0]         idcode_shift_reg;
    logic [31:0]         usercode_shift_reg;
    logic                bypass_reg;
    logic [BSR_LEN-1:0]  bsr_shift_reg;
    logic [BSR_LEN-1:0]  bsr_shifted;
    logic [BSR_LEN-1:0]  bsr_next;
    logic                bsr_sel;
    logic                tdo_next;

    jtag_tap_fsm u_fsm (
        .TCK        (TCK),
        .TRST       (TRST),
        .TMS        (TMS),
        .state      (state),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .tlr        (tlr)
    );

    // Unknown opcodes fall through to BYPASS so exactly one select is high.
    always_comb begin
        SAMPLE_SELECT   = 1'b0;
        EXTEST_SELECT   = 1'b0;
        INTEST_SELECT   = 1'b0;
        IDCODE_SELECT   = 1'b0;
        USERCODE_SELECT = 1'b0;
        BYPASS_SELECT   = 1'b0;
        if (LATCH_JTAG_IR == IR_SAMPLE)        SAMPLE_SELECT   = 1'b1;
        else if (LATCH_JTAG_IR == IR_EXTEST)   EXTEST_SELECT   = 1'b1;
        else if (LATCH_JTAG_IR == IR_INTEST)   INTEST_SELECT   = 1'b1;
        else if (LATCH_JTAG_IR == IR_IDCODE)   IDCODE_SELECT   = 1'b1;
        else if (LATCH_JTAG_IR == IR_USERCODE) USERCODE_SELECT = 1'b1;
        else                                   BYPASS_SELECT   = 1'b1;
    end

    assign bsr_sel = SAMPLE_SELECT | EXTEST_SELECT | INTEST_SELECT;

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            ir_shift_reg <= '0;
        end else if (capture_ir) begin
            ir_shift_reg <= IR_CAP_VAL;
        end else if (shift_ir) begin
            ir_shift_reg <= {TDI, ir_shift_reg[IR_WIDTH-1:1]};
        end
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            LATCH_JTAG_IR <= IR_IDCODE;
        end else if (tlr) begin
            LATCH_JTAG_IR <= IR_IDCODE;
        end else if (update_ir) begin
            LATCH_JTAG_IR <= ir_shift_reg;
        end
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            idcode_shift_reg   <= '0;
            usercode_shift_reg <= '0;
            bypass_reg         <= 1'b0;
        end else begin
            if (IDCODE_SELECT && capture_dr) idcode_shift_reg <= IDCODE_VAL;
            else if (IDCODE_SELECT && shift_dr) idcode_shift_reg <= {TDI, idcode_shift_reg[31:1]};
            if (USERCODE_SELECT && capture_dr) usercode_shift_reg <= USERCODE_VAL;
            else if (USERCODE_SELECT && shift_dr) usercode_shift_reg <= {TDI, usercode_shift_reg[31:1]};
            if (BYPASS_SELECT && capture_dr) bypass_reg <= 1'b0;
            else if (BYPASS_SELECT && shift_dr) bypass_reg <= TDI;
        end
    end

    // Generate-if keeps the top cell from ever indexing past the register.
    genvar gi;
    generate
        for (gi = 0; gi < BSR_LEN; gi++) begin : g_bsr
            if (gi == BSR_LEN - 1) begin : g_top
                assign bsr_shifted[gi] = TDI;
            end else begin : g_mid
                assign bsr_shifted[gi] = bsr_shift_reg[gi+1];
            end
            assign bsr_next[gi] = (bsr_sel && capture_dr) ? BSR_PI[gi]      :
                                  (bsr_sel && shift_dr)   ? bsr_shifted[gi] :
                                                            bsr_shift_reg[gi];
        end
    endgenerate

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            bsr_shift_reg <= '0;
        end else begin
            bsr_shift_reg <= bsr_next;
        end
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            BSR_PO <= '0;
        end else if (update_dr && bsr_sel) begin
            BSR_PO <= bsr_shift_reg;
        end
    end

    always_comb begin
        tdo_next = 1'b0;
        if (shift_ir) begin
            tdo_next = ir_shift_reg[0];
        end else if (shift_dr) begin
            if (IDCODE_SELECT)        tdo_next = idcode_shift_reg[0];
            else if (USERCODE_SELECT) tdo_next = usercode_shift_reg[0];
            else if (bsr_sel)         tdo_next = bsr_shift_reg[0];
            else                      tdo_next = bypass_reg;
        end
    end

    // Falling-edge launch gives the far end half a TCK of setup.
    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST) begin
            TDO    <= 1'b0;
            TDO_EN <= 1'b0;
        end else begin
            TDO    <= tdo_next;
            TDO_EN <= shift_ir | shift_dr;
        end
    end

endmodule

// File: tb/tb_jtag_tap_param.sv
// Bench for jtag_tap_param: default-parameter instance a and an
// IR_WIDTH=8 / BSR_LEN=33 instance b share TCK; TDO checked via scoreboard.
module tb_jtag_tap_param;

    logic tck = 1'b0;
    always #5 tck = ~tck;

    logic        trst_a, tms_a, tdi_a, tdo_a, tdo_en_a;
    logic [3:0]  state_a, ir_a;
    logic [9:0]  bsr_pi_a, bsr_po_a;
    logic        sample_a, extest_a, intest_a, idcode_a, bypass_a, usercode_a;

    logic        trst_b, tms_b, tdi_b, tdo_b, tdo_en_b;
    logic [3:0]  state_b;
    logic [7:0]  ir_b;
    logic [32:0] bsr_pi_b, bsr_po_b;
    logic        sample_b, extest_b, intest_b, idcode_b, bypass_b, usercode_b;

    jtag_tap_param dut_a (
        .TCK(tck), .TRST(trst_a), .TMS(tms_a), .TDI(tdi_a),
        .TDO(tdo_a), .TDO_EN(tdo_en_a), .state(state_a), .LATCH_JTAG_IR(ir_a),
        .BSR_PI(bsr_pi_a), .BSR_PO(bsr_po_a),
        .SAMPLE_SELECT(sample_a), .EXTEST_SELECT(extest_a), .INTEST_SELECT(intest_a),
        .IDCODE_SELECT(idcode_a), .BYPASS_SELECT(bypass_a), .USERCODE_SELECT(usercode_a)
    );

    jtag_tap_param #(.IR_WIDTH(8), .BSR_LEN(33)) dut_b (
        .TCK(tck), .TRST(trst_b), .TMS(tms_b), .TDI(tdi_b),
        .TDO(tdo_b), .TDO_EN(tdo_en_b), .state(state_b), .LATCH_JTAG_IR(ir_b),
        .BSR_PI(bsr_pi_b), .BSR_PO(bsr_po_b),
        .SAMPLE_SELECT(sample_b), .EXTEST_SELECT(extest_b), .INTEST_SELECT(intest_b),
        .IDCODE_SELECT(idcode_b), .BYPASS_SELECT(bypass_b), .USERCODE_SELECT(usercode_b)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    logic sb_q[$];

    typedef struct {
        logic       tms;
        logic [3:0] st;
        logic       en;
        logic       tdo;
        logic [3:0] ir;
    } vec_t;
    vec_t vecs[22];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One TCK period; returns 1 ns after the falling edge so TDO is settled.
    task automatic cyc(input bit which, input logic tms, input logic tdi);
        if (which) begin
            tms_b = tms; tdi_b = tdi;
        end else begin
            tms_a = tms; tdi_a = tdi;
        end
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    task automatic sample(input bit which, input string tag);
        logic exp_bit;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_underflow"}, 64'd1, 64'd0);
        end else begin
            exp_bit = sb_q.pop_front();
            chk({tag, "_tdo"}, which ? tdo_b : tdo_a, exp_bit);
            chk({tag, "_tdo_en"}, which ? tdo_en_b : tdo_en_a, 1'b1);
        end
    endtask

    // From Run-Test/Idle: n-bit shift through IR or DR, ending in Exit1.
    task automatic shift(input bit which, input bit is_ir, input int n,
                         input logic [63:0] din, input logic [63:0] dexp, input string tag);
        for (int i = 0; i < n; i++) sb_q.push_back(dexp[i]);
        cyc(which, 1'b1, 1'b0);
        if (is_ir) cyc(which, 1'b1, 1'b0);
        cyc(which, 1'b0, 1'b0);
        cyc(which, 1'b0, 1'b0);
        sample(which, tag);
        for (int i = 0; i < n; i++) begin
            cyc(which, (i == n - 1), din[i]);
            if (i < n - 1) sample(which, tag);
        end
        chk({tag, "_sb_left"}, 64'(sb_q.size()), 64'd0);
        sb_q.delete();
        $display("shift %s: %0d bits in=%0h expected out=%0h", tag, n, din, dexp);
    endtask

    task automatic update_to_rti(input bit which);
        cyc(which, 1'b1, 1'b0);
        cyc(which, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1'b1, 4'h7, 1'b0, 1'b0, 4'h7};
        vecs[1]  = '{1'b0, 4'h6, 1'b0, 1'b0, 4'h7};
        vecs[2]  = '{1'b1, 4'h1, 1'b0, 1'b0, 4'h7};
        vecs[3]  = '{1'b0, 4'h3, 1'b0, 1'b0, 4'h7};
        vecs[4]  = '{1'b0, 4'h3, 1'b0, 1'b0, 4'h7};
        vecs[5]  = '{1'b1, 4'h0, 1'b0, 1'b0, 4'h7};
        vecs[6]  = '{1'b0, 4'h2, 1'b1, 1'b1, 4'h7};
        vecs[7]  = '{1'b1, 4'h1, 1'b0, 1'b0, 4'h7};
        vecs[8]  = '{1'b1, 4'h5, 1'b0, 1'b0, 4'h7};
        vecs[9]  = '{1'b1, 4'h7, 1'b0, 1'b0, 4'h7};
        vecs[10] = '{1'b1, 4'h4, 1'b0, 1'b0, 4'h7};
        vecs[11] = '{1'b0, 4'hE, 1'b0, 1'b0, 4'h7};
        vecs[12] = '{1'b0, 4'hA, 1'b1, 1'b1, 4'h7};
        vecs[13] = '{1'b1, 4'h9, 1'b0, 1'b0, 4'h7};
        vecs[14] = '{1'b0, 4'hB, 1'b0, 1'b0, 4'h7};
        vecs[15] = '{1'b1, 4'h8, 1'b0, 1'b0, 4'h7};
        vecs[16] = '{1'b1, 4'hD, 1'b0, 1'b0, 4'h7};
        vecs[17] = '{1'b0, 4'hC, 1'b0, 1'b0, 4'h0};
        vecs[18] = '{1'b1, 4'h7, 1'b0, 1'b0, 4'h0};
        vecs[19] = '{1'b1, 4'h4, 1'b0, 1'b0, 4'h0};
        vecs[20] = '{1'b1, 4'hF, 1'b0, 1'b0, 4'h7};
        vecs[21] = '{1'b0, 4'hC, 1'b0, 1'b0, 4'h7};

        trst_a = 1'b0; trst_b = 1'b0;
        tms_a = 1'b1; tms_b = 1'b1; tdi_a = 1'b0; tdi_b = 1'b0;
        bsr_pi_a = '0; bsr_pi_b = '0;

        // Asynchronous reset, checked before any clock edge.
        #1 trst_a = 1'b1; trst_b = 1'b1;
        #1;
        chk("rst_state", state_a, 4'hF);
        chk("rst_ir", ir_a, 4'h7);
        chk("rst_idcode_sel", idcode_a, 1'b1);
        chk("rst_bsr_po", bsr_po_a, 10'h0);
        chk("rst_tdo", tdo_a, 1'b0);
        chk("rst_tdo_en", tdo_en_a, 1'b0);
        chk("rst_b_ir", ir_b, 8'h07);
        cyc(0, 1'b0, 1'b0);
        chk("rst_held_state", state_a, 4'hF);
        trst_a = 1'b0; trst_b = 1'b0;
        $display("reset released");

        for (int i = 0; i < 5; i++) begin
            cyc(0, 1'b1, 1'b0);
            chk("tms1_state", state_a, 4'hF);
        end
        cyc(0, 1'b0, 1'b0);
        chk("rti_state", state_a, 4'hC);
        chk("rti_ir", ir_a, 4'h7);

        // Walk through all sixteen states.
        for (int i = 0; i < 22; i++) begin
            cyc(0, vecs[i].tms, 1'b0);
            $display("fsm step %0d: tms=%0b state=%0h", i, vecs[i].tms, state_a);
            chk($sformatf("walk%0d_state", i), state_a, vecs[i].st);
            chk($sformatf("walk%0d_tdo_en", i), tdo_en_a, vecs[i].en);
            chk($sformatf("walk%0d_tdo", i), tdo_a, vecs[i].tdo);
            chk($sformatf("walk%0d_ir", i), ir_a, vecs[i].ir);
        end

        // IDCODE readout.
        shift(0, 1'b0, 32, 64'h0, 64'h1000_0001, "idcode");
        chk("idcode_exit_en", tdo_en_a, 1'b0);
        chk("idcode_exit_tdo", tdo_a, 1'b0);
        update_to_rti(0);
        chk("idcode_ir_hold", ir_a, 4'h7);

        // USERCODE readout.
        shift(0, 1'b1, 4, 64'h8, 64'h1, "ir_user");
        update_to_rti(0);
        chk("usercode_sel", usercode_a, 1'b1);
        shift(0, 1'b0, 32, 64'hFFFF_FFFF, 64'h0, "usercode");
        update_to_rti(0);

        // BYPASS: IR capture pattern out, one-cycle delay through DR.
        shift(0, 1'b1, 4, 64'hF, 64'h1, "ir_bypass");
        chk("bypass_ir_before_upd", ir_a, 4'h8);
        update_to_rti(0);
        chk("bypass_ir", ir_a, 4'hF);
        chk("bypass_sel", bypass_a, 1'b1);
        shift(0, 1'b0, 5, 64'b01101, 64'b11010, "bypass");
        update_to_rti(0);

        // EXTEST capture/shift/update.
        shift(0, 1'b1, 4, 64'h2, 64'h1, "ir_extest");
        update_to_rti(0);
        chk("extest_sel", extest_a, 1'b1);
        bsr_pi_a = 10'h2AA;
        shift(0, 1'b0, 10, 64'h155, 64'h2AA, "extest");
        chk("bsr_po_before_upd", bsr_po_a, 10'h0);
        update_to_rti(0);
        chk("bsr_po_after_upd", bsr_po_a, 10'h155);
        shift(0, 1'b0, 10, 64'h3FF, 64'h2AA, "extest2");
        chk("bsr_po_hold_shift", bsr_po_a, 10'h155);
        update_to_rti(0);
        chk("bsr_po_second", bsr_po_a, 10'h3FF);

        // Abort mid-shift with TRST from a clean reset.
        trst_a = 1'b1; #1; trst_a = 1'b0;
        cyc(0, 1'b0, 1'b0);
        shift(0, 1'b1, 4, 64'h2, 64'h1, "ir_abort");
        update_to_rti(0);
        bsr_pi_a = 10'h0F0;
        cyc(0, 1'b1, 1'b0);
        cyc(0, 1'b0, 1'b0);
        cyc(0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(0, 1'b0, 1'b1);
        chk("abort_in_shdr", state_a, 4'h2);
        trst_a = 1'b1;
        #1;
        $display("trst asserted mid-shift");
        chk("abort_state", state_a, 4'hF);
        chk("abort_ir", ir_a, 4'h7);
        chk("abort_bsr_po", bsr_po_a, 10'h0);
        chk("abort_tdo", tdo_a, 1'b0);
        chk("abort_tdo_en", tdo_en_a, 1'b0);
        trst_a = 1'b0;
        cyc(0, 1'b0, 1'b0);
        chk("abort_rti", state_a, 4'hC);
        shift(0, 1'b0, 32, 64'h0, 64'h1000_0001, "idcode_after_abort");
        update_to_rti(0);
        chk("abort_bsr_po_final", bsr_po_a, 10'h0);
        tms_a = 1'b1;

        // Wide instance: 8-bit IR, 33-bit BSR.
        cyc(1, 1'b0, 1'b0);
        chk("b_rti", state_b, 4'hC);
        shift(1, 1'b1, 8, 64'h05, 64'h01, "b_ir_05");
        update_to_rti(1);
        chk("b_ir", ir_b, 8'h05);
        chk("b_bypass_sel", bypass_b, 1'b1);
        shift(1, 1'b0, 3, 64'b101, 64'b010, "b_bypass");
        update_to_rti(1);
        shift(1, 1'b1, 8, 64'h02, 64'h01, "b_ir_extest");
        update_to_rti(1);
        chk("b_extest_sel", extest_b, 1'b1);
        bsr_pi_b = 33'h1_2345_6789;
        shift(1, 1'b0, 33, 64'h0_F0F0_A5A5, 64'h1_2345_6789, "b_bsr");
        chk("b_bsr_po_before", bsr_po_b, 33'h0);
        update_to_rti(1);
        chk("b_bsr_po", bsr_po_b, 33'h0_F0F0_A5A5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
